output_sram_writer: RTL and testbench
=====================================

# output_sram_writer

Upstream neighbour of the output streamer. Accepts signed accumulator results from the compute engine over an AXI-Stream slave, requantises each (rounding arithmetic right shift, saturate to 2*DATA_WIDTH), and writes them to output SRAM at addresses 0..out_size-1. After the last write it asserts `start_output` to the output streamer and holds it until the streamer reports completion.

## Interface
- ADDR_WIDTH, 13: output SRAM address width.
- DATA_WIDTH, 8: element width; SRAM word is 2*DATA_WIDTH signed.
- ACC_WIDTH, 32: accumulator input width, signed.
- s_axis_aclk  in  1  sole clock.
- s_axis_aresetn  in  1  reset; asynchronous, active-low.
- s_axis_tdata  in  ACC_WIDTH  signed accumulator value.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  combinational, = (state==WRITE).
- s_axis_tlast  in  1  marks final beat of a tensor.
- start  in  1  one-cycle job start pulse.
- out_size  in  ADDR_WIDTH+1  element count, 1..2^ADDR_WIDTH; sampled on `start`.
- shift_amt  in  5  requant right shift; sampled on `start`.
- busy  out  1  state != IDLE.
- err_tlast  out  1  sticky tlast-mismatch flag; cleared by accepted `start`.
- sram_we  out  1  output-SRAM write strobe.
- sram_addr  out  ADDR_WIDTH  write address.
- sram_data_in  out  2*DATA_WIDTH  signed write data.
- start_output  out  1  level to output streamer: SRAM holds a complete tensor.
- output_done  in  1  one-cycle pulse from streamer after its last beat.

## Operation
- FSM IDLE -> WRITE -> HANDOFF -> IDLE.
- IDLE: `start` with out_size!=0 latches size and shift, count<=0, clears err_tlast, -> WRITE. `start` with out_size==0 ignored.
- WRITE: each handshake (tvalid&tready) issues one registered write: sram_we<=1, sram_addr<=count, sram_data_in<=requant(tdata); count++. No handshake -> sram_we<=0 (addr/data hold).
- Handshake with count==size-1 -> HANDOFF. tlast on an earlier beat, or missing on the final beat, sets err_tlast; count alone governs termination.
- HANDOFF: tready=0; start_output high until `output_done`, then start_output<=0, -> IDLE.
- `start` while busy ignored; `output_done` outside HANDOFF ignored.
- Requant: s = min(shift_amt, ACC_WIDTH-1). s==0: v=acc; else v=(acc + 2^(s-1)) >>> s computed in ACC_WIDTH+1 bits (no wrap). Saturate v to [-2^(2*DATA_WIDTH-1), 2^(2*DATA_WIDTH-1)-1].

## Timing
- Reset (async assert, sync deassert externally): state=IDLE, count=0, sram_we=0, sram_addr=0, sram_data_in=0, start_output=0, err_tlast=0, busy=0.
- Reset mid-job aborts immediately; partial SRAM contents undefined, no start_output.
- Write latency: handshake at edge k -> sram_we/addr/data valid during cycle k..k+1 (one register stage).
- Throughput: one element per cycle with tvalid held high.
- start_output rises at edge k+1 after final handshake at edge k (one cycle after the last write strobe, so the streamer's first read follows all writes).
- output_done at edge m -> start_output low and busy low after edge m.
- out_size==2^ADDR_WIDTH: addresses 0..2^ADDR_WIDTH-1, count compared in ADDR_WIDTH+1 bits, no wrap.

## Structure
- Shared package `npu_out_pkg`: FSM state encoding (IDLE/WRITE/HANDOFF), SAT_MAX/SAT_MIN derived from DATA_WIDTH, shift width constant.
- One combinational sub-module `requant_sat` (round-shift + saturate, parameterised ACC_WIDTH/DATA_WIDTH); FSM, counter and write register in top.

## Test plan
- out_size=4, shift=0, tdata 1,-2,300,-40000, tlast on 4th -> writes addr0..3 = 1,-2,300,-32768; start_output one cycle after last sram_we; err_tlast=0.
- shift=4, tdata 24, 23, -24, 0x7FFFFFFF -> 2 (round half up), 1, -1, 32767.
- out_size=3, tlast on beat 2 -> err_tlast=1, third beat still accepted and written, then HANDOFF.
- tvalid toggling 1,0,1,0 -> sram_we only after handshakes, addresses contiguous; `start` pulse in WRITE ignored; output_done in WRITE ignored.
- HANDOFF held 20 cycles, then output_done pulse -> start_output low, busy low next cycle; new start accepted.
- Reset asserted after 2 of 5 beats -> all outputs at reset values asynchronously; subsequent out_size=1 job completes normally.

Source files
------------

// File: rtl/npu_out_pkg.sv
// Shared definitions for the output-side writer: FSM encoding, shift width and
// saturation bounds for the 2*DATA_WIDTH SRAM word.
package npu_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_HANDOFF = 2'd2
    } out_state_e;

    localparam int SHIFT_W        = 5;
    localparam int DEF_DATA_WIDTH = 8;

    function automatic longint sat_max(input int data_width);
        return (longint'(1) <<< (2 * data_width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int data_width);
        return -(longint'(1) <<< (2 * data_width - 1));
    endfunction

    localparam longint SAT_MAX = sat_max(DEF_DATA_WIDTH);
    localparam longint SAT_MIN = sat_min(DEF_DATA_WIDTH);

endpackage

// File: rtl/requant_sat.sv
// Combinational requantiser: rounding arithmetic right shift of a signed
// accumulator followed by saturation to a 2*DATA_WIDTH signed word.
module requant_sat
    import npu_out_pkg::*;
#(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [ACC_WIDTH-1:0]    acc,
    input  logic        [SHIFT_W-1:0]      shift_amt,
    output logic signed [2*DATA_WIDTH-1:0] result
);

    localparam int OUT_W     = 2 * DATA_WIDTH;
    localparam int EXT_W     = ACC_WIDTH + 1;
    localparam int MAX_SHIFT = ACC_WIDTH - 1;
    localparam logic signed [EXT_W-1:0] V_MAX = EXT_W'(sat_max(DATA_WIDTH));
    localparam logic signed [EXT_W-1:0] V_MIN = EXT_W'(sat_min(DATA_WIDTH));

    int                      s_eff;
    logic signed [EXT_W-1:0] acc_ext;
    logic signed [EXT_W-1:0] rounded;

    // One extra bit of headroom so adding the rounding constant never wraps.
    always_comb begin
        s_eff   = (int'(shift_amt) > MAX_SHIFT) ? MAX_SHIFT : int'(shift_amt);
        acc_ext = {acc[ACC_WIDTH-1], acc};
        if (s_eff == 0) begin
            rounded = acc_ext;
        end else begin
            rounded = (acc_ext + (EXT_W'(1) <<< (s_eff - 1))) >>> s_eff;
        end

        if (rounded > V_MAX) begin
            result = V_MAX[OUT_W-1:0];
        end else if (rounded < V_MIN) begin
            result = V_MIN[OUT_W-1:0];
        end else begin
            result = rounded[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/output_sram_writer.sv
// Accepts accumulator beats over AXI-Stream, requantises them into output SRAM
// at consecutive addresses, then raises start_output until the streamer is done.
module output_sram_writer
    import npu_out_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                           s_axis_aclk,
    input  logic                           s_axis_aresetn,
    input  logic signed [ACC_WIDTH-1:0]    s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    input  logic                           start,
    input  logic        [ADDR_WIDTH:0]     out_size,
    input  logic        [SHIFT_W-1:0]      shift_amt,
    output logic                           busy,
    output logic                           err_tlast,
    output logic                           sram_we,
    output logic        [ADDR_WIDTH-1:0]   sram_addr,
    output logic signed [2*DATA_WIDTH-1:0] sram_data_in,
    output logic                           start_output,
    input  logic                           output_done
);

    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);

    out_state_e                     state;
    logic        [ADDR_WIDTH:0]     count;
    logic        [ADDR_WIDTH:0]     size_q;
    logic        [SHIFT_W-1:0]      shift_q;
    logic signed [2*DATA_WIDTH-1:0] req_data;
    logic                           handshake;
    logic                           last_beat;

    requant_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_requant (
        .acc       (s_axis_tdata),
        .shift_amt (shift_q),
        .result    (req_data)
    );

    assign s_axis_tready = (state == ST_WRITE);
    assign busy          = (state != ST_IDLE);
    assign handshake     = s_axis_tvalid & s_axis_tready;
    // Count is one bit wider than the address so a full 2^ADDR_WIDTH job ends cleanly.
    assign last_beat     = (count == (size_q - ONE));

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state        <= ST_IDLE;
            count        <= '0;
            size_q       <= '0;
            shift_q      <= '0;
            sram_we      <= 1'b0;
            sram_addr    <= '0;
            sram_data_in <= '0;
            start_output <= 1'b0;
            err_tlast    <= 1'b0;
        end else begin
            sram_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && (out_size != '0)) begin
                        size_q    <= out_size;
                        shift_q   <= shift_amt;
                        count     <= '0;
                        err_tlast <= 1'b0;
                        state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (handshake) begin
                        sram_we      <= 1'b1;
                        sram_addr    <= count[ADDR_WIDTH-1:0];
                        sram_data_in <= req_data;
                        count        <= count + ONE;
                        // tlast is only checked; the element count alone ends the job.
                        if (last_beat) begin
                            if (!s_axis_tlast) begin
                                err_tlast <= 1'b1;
                            end
                            state <= ST_HANDOFF;
                        end else if (s_axis_tlast) begin
                            err_tlast <= 1'b1;
                        end
                    end
                end
                ST_HANDOFF: begin
                    if (output_done) begin
                        start_output <= 1'b0;
                        state        <= ST_IDLE;
                    end else begin
                        start_output <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_sram_writer.sv
// Self-checking bench for output_sram_writer: directed and randomised jobs
// compared against an arithmetic requantisation model and write scoreboard.
module tb_output_sram_writer;

    localparam int ADDR_WIDTH = 13;
    localparam int DATA_WIDTH = 8;
    localparam int ACC_WIDTH  = 32;

    logic                           s_axis_aclk = 1'b0;
    logic                           s_axis_aresetn;
    logic        [ACC_WIDTH-1:0]    s_axis_tdata;
    logic                           s_axis_tvalid;
    logic                           s_axis_tready;
    logic                           s_axis_tlast;
    logic                           start;
    logic        [ADDR_WIDTH:0]     out_size;
    logic        [4:0]              shift_amt;
    logic                           busy;
    logic                           err_tlast;
    logic                           sram_we;
    logic        [ADDR_WIDTH-1:0]   sram_addr;
    logic        [2*DATA_WIDTH-1:0] sram_data_in;
    logic                           start_output;
    logic                           output_done;

    int vectors    = 0;
    int miscompares = 0;

    int acc_q[$];
    int wr_addr_q[$];
    int wr_data_q[$];

    output_sram_writer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) dut (
        .s_axis_aclk    (s_axis_aclk),
        .s_axis_aresetn (s_axis_aresetn),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .start          (start),
        .out_size       (out_size),
        .shift_amt      (shift_amt),
        .busy           (busy),
        .err_tlast      (err_tlast),
        .sram_we        (sram_we),
        .sram_addr      (sram_addr),
        .sram_data_in   (sram_data_in),
        .start_output   (start_output),
        .output_done    (output_done)
    );

    always #5 s_axis_aclk = ~s_axis_aclk;

    // Capture every SRAM write strobe shortly after the edge that launched it.
    always @(posedge s_axis_aclk) begin
        #1;
        if (sram_we === 1'b1) begin
            wr_addr_q.push_back(int'(sram_addr));
            wr_data_q.push_back(int'($signed(sram_data_in)));
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=hang expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic longint requant_model(input longint acc, input int shift);
        int     s;
        longint v;
        s = (shift > ACC_WIDTH - 1) ? ACC_WIDTH - 1 : shift;
        if (s == 0) begin
            v = acc;
        end else begin
            v = (acc + (longint'(1) << (s - 1))) >>> s;
        end
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    task automatic check_output(input string tag, input longint observed, input longint expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int rand_acc();
        if ($urandom_range(0, 3) == 0) begin
            return int'($urandom());
        end
        return int'($urandom_range(0, 200000)) - 100000;
    endfunction

    task automatic run_job(input int n, input int shift, input bit rand_valid,
                           input int tlast_beat, input bit inject, input int hold);
        int i;
        int guard;
        wr_addr_q.delete();
        wr_data_q.delete();
        start     = 1'b1;
        out_size  = (ADDR_WIDTH + 1)'(n);
        shift_amt = 5'(shift);
        @(negedge s_axis_aclk);
        start = 1'b0;
        check_output("busy_after_start", busy, 1);
        check_output("tready_in_write", s_axis_tready, 1);
        check_output("err_cleared_on_start", err_tlast, 0);
        i = 0;
        guard = 0;
        while (i < n) begin
            s_axis_tvalid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axis_tdata  = acc_q[i];
            s_axis_tlast  = (i == tlast_beat);
            start         = inject && (guard == 1);
            out_size      = inject ? (ADDR_WIDTH + 1)'(3) : (ADDR_WIDTH + 1)'(n);
            output_done   = inject && (guard == 2);
            @(posedge s_axis_aclk);
            if (s_axis_tvalid) i++;
            @(negedge s_axis_aclk);
            guard++;
            if (guard > 4 * n + 50) begin
                check_output("beat_timeout_handshakes", i, n);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        start         = 1'b0;
        output_done   = 1'b0;
        check_output("last_we", sram_we, 1);
        check_output("last_addr", sram_addr, n - 1);
        check_output("start_output_not_early", start_output, 0);
        check_output("tready_in_handoff", s_axis_tready, 0);
        @(negedge s_axis_aclk);
        check_output("start_output_rise", start_output, 1);
        check_output("we_after_last", sram_we, 0);
        repeat (hold) @(negedge s_axis_aclk);
        check_output("start_output_held", start_output, 1);
        check_output("busy_in_handoff", busy, 1);
        output_done = 1'b1;
        @(negedge s_axis_aclk);
        output_done = 1'b0;
        check_output("start_output_drop", start_output, 0);
        check_output("busy_drop", busy, 0);
        check_output("err_tlast", err_tlast, (tlast_beat != n - 1) ? 1 : 0);
        check_output("write_count", wr_addr_q.size(), n);
        for (int j = 0; j < n && j < wr_addr_q.size(); j++) begin
            check_output("write_addr", wr_addr_q[j], j);
            check_output("write_data", wr_data_q[j], requant_model(longint'(acc_q[j]), shift));
        end
    endtask

    initial begin
        int n;
        s_axis_aresetn = 1'b0;
        s_axis_tdata   = '0;
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        start          = 1'b0;
        out_size       = '0;
        shift_amt      = '0;
        output_done    = 1'b0;
        #1;
        check_output("rst_busy", busy, 0);
        check_output("rst_we", sram_we, 0);
        check_output("rst_addr", sram_addr, 0);
        check_output("rst_data", sram_data_in, 0);
        check_output("rst_start_output", start_output, 0);
        check_output("rst_err", err_tlast, 0);
        check_output("rst_tready", s_axis_tready, 0);
        repeat (3) @(negedge s_axis_aclk);
        s_axis_aresetn = 1'b1;
        @(negedge s_axis_aclk);

        // Zero-size start is ignored
        start    = 1'b1;
        out_size = '0;
        @(negedge s_axis_aclk);
        start = 1'b0;
        check_output("zero_size_ignored", busy, 0);

        // Directed: shift 0, saturation negative
        acc_q = '{1, -2, 300, -40000};
        run_job(4, 0, 1'b0, 3, 1'b0, 1);
        check_output("directed_sat_neg", wr_data_q.size() > 3 ? wr_data_q[3] : 0, -32768);

        // Directed: shift 4, round half up, saturation positive
        acc_q = '{24, 23, -24, 32'h7FFFFFFF};
        run_job(4, 4, 1'b0, 3, 1'b0, 2);
        check_output("directed_round_half", wr_data_q.size() > 0 ? wr_data_q[0] : 0, 2);
        check_output("directed_sat_pos", wr_data_q.size() > 3 ? wr_data_q[3] : 0, 32767);

        // Early tlast
        acc_q = '{10, 20, 30};
        run_job(3, 1, 1'b0, 1, 1'b0, 1);

        // Toggling valid, ignored start/output_done inside WRITE, long handoff
        acc_q.delete();
        for (int k = 0; k < 8; k++) acc_q.push_back(rand_acc());
        run_job(8, int'($urandom_range(0, 31)), 1'b1, 7, 1'b1, 20);

        // Randomised jobs
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 24));
            acc_q.delete();
            for (int k = 0; k < n; k++) acc_q.push_back(rand_acc());
            run_job(n, int'($urandom_range(0, 31)), r[0], ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : n - 1, 1'b0, int'($urandom_range(1, 5)));
        end

        // Mid-job asynchronous reset after 2 of 5 beats
        start     = 1'b1;
        out_size  = (ADDR_WIDTH + 1)'(5);
        shift_amt = 5'd2;
        @(negedge s_axis_aclk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = rand_acc();
            @(negedge s_axis_aclk);
        end
        #2;
        s_axis_aresetn = 1'b0;
        #1;
        check_output("midrst_busy", busy, 0);
        check_output("midrst_we", sram_we, 0);
        check_output("midrst_addr", sram_addr, 0);
        check_output("midrst_data", sram_data_in, 0);
        check_output("midrst_start_output", start_output, 0);
        check_output("midrst_tready", s_axis_tready, 0);
        s_axis_tvalid = 1'b0;
        @(negedge s_axis_aclk);
        s_axis_aresetn = 1'b1;
        @(negedge s_axis_aclk);
        acc_q = '{-77777};
        run_job(1, 3, 1'b0, 0, 1'b0, 1);

        // Full-depth job: every address used, no wrap
        n = 1 << ADDR_WIDTH;
        acc_q.delete();
        for (int k = 0; k < n; k++) acc_q.push_back(rand_acc());
        run_job(n, int'($urandom_range(0, 31)), 1'b0, n - 1, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
